// File: rtl/jtag_master_pkg.sv
// Shared types and constants for the on-chip JTAG initiator.
package jtag_master_pkg;

    localparam int MAX_BITS = 32;
    localparam int LEN_W    = 6;

    localparam logic [LEN_W-1:0] MAX_LEN = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Lengths above the vector width shift the whole vector and no more.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > MAX_LEN) begin
            clamp_len = MAX_LEN;
        end else begin
            clamp_len = len;
        end
    endfunction

endpackage

// File: rtl/jtag_master_if.sv
// Command/response handshake bundle between the control logic and the JTAG initiator.
interface jtag_master_if;
    import jtag_master_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LEN_W-1:0]     cmd_len;
    logic [MAX_BITS-1:0]  cmd_tms;
    logic [MAX_BITS-1:0]  cmd_tdi;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [MAX_BITS-1:0]  resp_tdo;

    // Control side: issues commands and consumes responses.
    modport master (
        output cmd_valid, cmd_len, cmd_tms, cmd_tdi, resp_ready,
        input  cmd_ready, resp_valid, resp_tdo
    );

    // Initiator side: accepts commands and produces responses.
    modport slave (
        input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, resp_ready,
        output cmd_ready, resp_valid, resp_tdo
    );

endinterface

// File: rtl/jtag_tck_gen.sv
// Half-period timer: strobes o_phase_done every HALF enabled cycles after a restart.
module jtag_tck_gen #(
    parameter int HALF = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_phase_done
);

    localparam int              CNT_W  = $clog2(HALF + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // The strobe lands on the edge that completes HALF cycles of the current phase.
    assign o_phase_done = i_enable && !i_restart && (r_cnt == ZERO);

    // Down-counter reloaded on restart and at the end of every phase (each tck toggle).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= ZERO;
        end else if (i_restart) begin
            r_cnt <= RELOAD;
        end else if (i_enable) begin
            if (r_cnt == ZERO) begin
                r_cnt <= RELOAD;
            end else begin
                r_cnt <= r_cnt - ONE;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/jtag_master.sv
// On-chip JTAG initiator: shifts up to 32 TMS/TDI bits and returns captured TDO.
module jtag_master
    import jtag_master_pkg::*;
#(
    parameter int HALF = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    jtag_master_if.slave  bus,
    output logic          busy,
    output logic          tck,
    output logic          tms,
    output logic          tdi,
    input  logic          tdo
);

    state_e               r_state;
    logic                 r_cmd_ready;
    logic                 r_resp_valid;
    logic                 r_busy;
    logic                 r_tck;
    logic                 r_tms;
    logic                 r_tdi;
    logic [MAX_BITS-1:0]  r_cap;
    logic [MAX_BITS-1:0]  r_tms_sh;
    logic [MAX_BITS-1:0]  r_tdi_sh;
    logic [4:0]           r_idx;
    logic [LEN_W-1:0]     r_len;

    logic                 w_accept;
    logic                 w_phase_done;
    logic                 w_enable;
    logic                 w_last;
    logic [LEN_W-1:0]     w_len;

    assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_enable = (r_state == ST_LOW) || (r_state == ST_HIGH);
    assign w_len    = clamp_len(bus.cmd_len);
    assign w_last   = ({1'b0, r_idx} == (r_len - 6'd1));

    jtag_tck_gen #(
        .HALF (HALF)
    ) u_tck_gen (
        .i_clk        (wb_clk_i),
        .i_rst        (wb_rst_i),
        .i_enable     (w_enable),
        .i_restart    (w_accept),
        .o_phase_done (w_phase_done)
    );

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_tdo   = r_cap;
    assign busy           = r_busy;
    assign tck            = r_tck;
    assign tms            = r_tms;
    assign tdi            = r_tdi;

    // Shift FSM: TMS/TDI move only on the accept edge or a falling tck edge,
    // TDO is captured on each rising tck edge; handshake flags track the state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_tck        <= 1'b0;
            r_tms        <= 1'b1;
            r_tdi        <= 1'b0;
            r_cap        <= 32'h0000_0000;
            r_tms_sh     <= 32'h0000_0000;
            r_tdi_sh     <= 32'h0000_0000;
            r_idx        <= 5'd0;
            r_len        <= 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_tms_sh    <= bus.cmd_tms;
                        r_tdi_sh    <= bus.cmd_tdi;
                        r_len       <= w_len;
                        r_cap       <= 32'h0000_0000;
                        r_idx       <= 5'd0;
                        r_tms       <= bus.cmd_tms[0];
                        r_tdi       <= bus.cmd_tdi[0];
                        r_tck       <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_len == 6'd0) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    if (w_phase_done) begin
                        r_tck        <= 1'b1;
                        r_cap[r_idx] <= tdo;
                        r_state      <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_phase_done) begin
                        r_tck <= 1'b0;
                        if (w_last) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_idx    <= r_idx + 5'd1;
                            r_tms    <= r_tms_sh[1];
                            r_tdi    <= r_tdi_sh[1];
                            r_tms_sh <= {1'b0, r_tms_sh[MAX_BITS-1:1]};
                            r_tdi_sh <= {1'b0, r_tdi_sh[MAX_BITS-1:1]};
                            r_state  <= ST_LOW;
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_cmd_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cmd_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_tck        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master: HALF=2 instance for function/handshake/reset,
// HALF=1 instance for pin timing.
module tb_jtag_master;
    import jtag_master_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtag_master_if bus1 ();
    jtag_master_if bus2 ();

    logic busy1, tck1, tms1, tdi1, tdo1;
    logic busy2, tck2, tms2, tdi2, tdo2;

    jtag_master #(.HALF(2)) dut1 (
        .wb_clk_i (clk), .wb_rst_i (rst), .bus (bus1),
        .busy (busy1), .tck (tck1), .tms (tms1), .tdi (tdi1), .tdo (tdo1)
    );

    jtag_master #(.HALF(1)) dut2 (
        .wb_clk_i (clk), .wb_rst_i (rst), .bus (bus2),
        .busy (busy2), .tck (tck2), .tms (tms2), .tdi (tdi2), .tdo (tdo2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // ---------------- dut1 pin monitor and TDO target model ----------------
    int          rise1 = 0;
    int          fall1 = 0;
    logic        prev_tck1 = 1'b0;
    logic [63:0] tms_hist1 = 64'h0;
    logic [63:0] tdi_hist1 = 64'h0;
    logic [31:0] tdo_pat1  = 32'h0;
    int          tdo_base1 = 0;

    // Counts tck edges of dut1 and records TMS/TDI seen at each rising edge.
    always @(negedge clk) begin
        prev_tck1 <= tck1;
        if (tck1 === 1'b1 && prev_tck1 === 1'b0) begin
            rise1     <= rise1 + 1;
            tms_hist1 <= {tms_hist1[62:0], tms1};
            tdi_hist1 <= {tdi_hist1[62:0], tdi1};
        end
        if (tck1 === 1'b0 && prev_tck1 === 1'b1) begin
            fall1 <= fall1 + 1;
        end
    end

    // Target shifts its TDO word out LSB first, advancing on each tck fall.
    always_comb begin
        tdo1 = 1'b0;
        if ((fall1 - tdo_base1) < 32) tdo1 = tdo_pat1[5'(fall1 - tdo_base1)];
    end

    // ---------------- dut2 timing monitor (loopback target) ----------------
    assign tdo2 = tdi2;

    int          rise2 = 0;
    int          viol2 = 0;
    int          bad_per2 = 0;
    int          cyc2 = 0;
    int          last_rise2 = 0;
    logic        have_last2 = 1'b0;
    logic        prev_tck2 = 1'b0;
    logic        prev_tms2 = 1'b1;
    logic        prev_tdi2 = 1'b0;
    logic [63:0] tms_hist2 = 64'h0;
    logic [63:0] tdi_hist2 = 64'h0;

    // Flags TMS/TDI moving while tck is high or on a rising edge, and checks tck period.
    always @(negedge clk) begin
        prev_tck2 <= tck2;
        prev_tms2 <= tms2;
        prev_tdi2 <= tdi2;
        cyc2      <= cyc2 + 1;
        if (tck2 === 1'b1 && ((tms2 !== prev_tms2) || (tdi2 !== prev_tdi2))) viol2 <= viol2 + 1;
        if (tck2 === 1'b1 && prev_tck2 === 1'b0) begin
            rise2      <= rise2 + 1;
            tms_hist2  <= {tms_hist2[62:0], tms2};
            tdi_hist2  <= {tdi_hist2[62:0], tdi2};
            if (have_last2 && (cyc2 - last_rise2 != 2)) bad_per2 <= bad_per2 + 1;
            last_rise2 <= cyc2;
            have_last2 <= 1'b1;
        end else if (busy2 !== 1'b1) begin
            have_last2 <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Issues one command on dut1, waits for the response, optionally stalls
    // resp_ready for 'hold' cycles (with a stray cmd_valid pulse), then consumes it.
    task automatic run_cmd(input logic [5:0] len, input logic [31:0] tmsv, input logic [31:0] tdiv,
                           input logic [31:0] patt, input int hold,
                           output int cyc, output logic [31:0] tdo_res, output int nrise);
        int r0;
        @(negedge clk);
        bus1.cmd_valid = 1'b1;
        bus1.cmd_len   = len;
        bus1.cmd_tms   = tmsv;
        bus1.cmd_tdi   = tdiv;
        tdo_pat1       = patt;
        tdo_base1      = fall1;
        r0             = rise1;
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        cyc = 0;
        while (bus1.resp_valid !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (bus1.resp_valid !== 1'b1) check("resp_timeout", 64'd0, 64'd1);
        tdo_res = bus1.resp_tdo;
        nrise   = rise1 - r0;
        for (int k = 0; k < hold; k++) begin
            if (k == 4) begin
                bus1.cmd_valid = 1'b1;
                bus1.cmd_len   = 6'd8;
                bus1.cmd_tms   = 32'h0000_00FF;
                bus1.cmd_tdi   = 32'h0000_00FF;
            end else begin
                bus1.cmd_valid = 1'b0;
            end
            @(negedge clk);
            check("hold_valid", bus1.resp_valid, 1'b1);
            check("hold_tdo", bus1.resp_tdo, tdo_res);
            check("hold_cmd_ready", bus1.cmd_ready, 1'b0);
            check("hold_tck", tck1, 1'b0);
        end
        bus1.cmd_valid  = 1'b0;
        bus1.resp_ready = 1'b1;
        @(negedge clk);
        bus1.resp_ready = 1'b0;
        check("post_cmd_ready", bus1.cmd_ready, 1'b1);
        check("post_resp_valid", bus1.resp_valid, 1'b0);
    endtask

    int          cyc, nr, r0, k;
    logic [31:0] res;
    logic        saw_valid;

    initial begin
        bus1.cmd_valid = 1'b0; bus1.cmd_len = 6'd0; bus1.cmd_tms = 32'h0; bus1.cmd_tdi = 32'h0;
        bus1.resp_ready = 1'b0;
        bus2.cmd_valid = 1'b0; bus2.cmd_len = 6'd0; bus2.cmd_tms = 32'h0; bus2.cmd_tdi = 32'h0;
        bus2.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values
        check("rst_tck", tck1, 1'b0);
        check("rst_tms", tms1, 1'b1);
        check("rst_tdi", tdi1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_cmd_ready", bus1.cmd_ready, 1'b1);
        check("rst_resp_valid", bus1.resp_valid, 1'b0);
        check("rst_resp_tdo", bus1.resp_tdo, 32'h0);

        // TAP reset: 5 bits of TMS=1 -> 20 cycles at HALF=2
        run_cmd(6'd5, 32'h0000_001F, 32'h0, 32'h0, 0, cyc, res, nr);
        check("tap_cycles", cyc, 20);
        check("tap_rises", nr, 5);
        check("tap_tdo", res, 32'h0);
        check("tap_tms_hist", tms_hist1[4:0], 5'h1F);

        // IDCODE shift
        run_cmd(6'd32, 32'h8000_0000, 32'h0, 32'h1000_563D, 0, cyc, res, nr);
        check("id_cycles", cyc, 128);
        check("id_rises", nr, 32);
        check("id_tdo", res, 32'h1000_563D);
        check("id_tms_hist", tms_hist1[31:0], 32'h0000_0001);
        check("id_tms_hold_last", tms1, 1'b1);

        // len=0 no-op
        run_cmd(6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc, res, nr);
        check("len0_cycles", cyc, 0);
        check("len0_rises", nr, 0);
        check("len0_tdo", res, 32'h0);

        // len=40 clamps to 32
        run_cmd(6'd40, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, cyc, res, nr);
        check("len40_cycles", cyc, 128);
        check("len40_rises", nr, 32);
        check("len40_tdo", res, 32'hFFFF_FFFF);

        // len=1 with TDO high: upper bits must read 0
        run_cmd(6'd1, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, cyc, res, nr);
        check("len1_cycles", cyc, 4);
        check("len1_rises", nr, 1);
        check("len1_tdo", res, 32'h0000_0001);

        // Response back-pressure with a stray command in the stall window
        r0 = rise1;
        run_cmd(6'd3, 32'h0, 32'h0000_0006, 32'h0000_0005, 10, cyc, res, nr);
        check("bp_tdo", res, 32'h0000_0005);
        check("bp_tdi_hist", tdi_hist1[2:0], 3'b011);
        repeat (6) @(negedge clk);
        check("bp_ignored_busy", busy1, 1'b0);
        check("bp_ignored_rises", rise1 - r0, 3);

        // Reset during HIGH of bit 3
        @(negedge clk);
        bus1.cmd_valid = 1'b1; bus1.cmd_len = 6'd8;
        bus1.cmd_tms = 32'h0; bus1.cmd_tdi = 32'hFFFF_FFFF;
        tdo_pat1 = 32'h0; tdo_base1 = fall1;
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        nr = 0; k = 0; prev_tck1 = prev_tck1;
        begin
            logic pt;
            pt = tck1;
            while (nr < 4 && k < 200) begin
                @(negedge clk);
                if (tck1 === 1'b1 && pt === 1'b0) nr++;
                pt = tck1;
                k++;
            end
        end
        check("mid_reach_bit3", nr, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_tck", tck1, 1'b0);
        check("mid_tms", tms1, 1'b1);
        check("mid_tdi", tdi1, 1'b0);
        check("mid_busy", busy1, 1'b0);
        check("mid_cmd_ready", bus1.cmd_ready, 1'b1);
        saw_valid = bus1.resp_valid;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.resp_valid === 1'b1) saw_valid = 1'b1;
        end
        check("mid_no_resp", saw_valid, 1'b0);
        run_cmd(6'd4, 32'h0, 32'h0, 32'h0000_000A, 0, cyc, res, nr);
        check("after_rst_cycles", cyc, 16);
        check("after_rst_tdo", res, 32'h0000_000A);

        // HALF=1 timing on dut2 with TDO looped back from TDI
        @(negedge clk);
        bus2.cmd_valid = 1'b1; bus2.cmd_len = 6'd8;
        bus2.cmd_tms = 32'h0000_0035; bus2.cmd_tdi = 32'h0000_000F;
        r0 = rise2;
        @(negedge clk);
        bus2.cmd_valid = 1'b0;
        cyc = 0;
        while (bus2.resp_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("h1_cycles", cyc, 16);
        check("h1_tdo", bus2.resp_tdo, 32'h0000_000F);
        bus2.resp_ready = 1'b1;
        @(negedge clk);
        bus2.resp_ready = 1'b0;
        check("h1_rises", rise2 - r0, 8);
        check("h1_tms_hist", tms_hist2[7:0], 8'hAC);
        check("h1_tdi_hist", tdi_hist2[7:0], 8'hF0);
        check("h1_pin_violations", viol2, 0);
        check("h1_bad_periods", bad_per2, 0);
        check("h1_cmd_ready", bus2.cmd_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
